// File: rtl/button_capture_if.sv
// Player-button receiver bus: input enable and raw buttons in, colour events out.
interface button_capture_if;
    logic       en;
    logic [3:0] buttons;
    logic       colour_valid;
    logic [1:0] colour_val;
    logic       multi_press;
    logic       busy;

    // Game controller side: drives enable and buttons, consumes events.
    modport master (
        output en,
        output buttons,
        input  colour_valid,
        input  colour_val,
        input  multi_press,
        input  busy
    );

    // Receiver side.
    modport slave (
        input  en,
        input  buttons,
        output colour_valid,
        output colour_val,
        output multi_press,
        output busy
    );
endinterface

// File: rtl/button_capture.sv
// Simon Says player-input receiver: synchronises and debounces four colour
// buttons, emitting one colour event per physical press, or a multi-press
// error pulse when more than one button was held at acceptance.
module button_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic           clk,
    input  logic           rst,
    button_capture_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       w_bsync;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_counter;
    logic [CNT_W-1:0] w_counter_nxt;
    logic [CNT_W-1:0] w_counter_inc;
    logic [3:0]       r_sample;
    logic [3:0]       w_sample_nxt;
    logic             r_colour_valid;
    logic             w_colour_valid_nxt;
    logic [1:0]       r_colour_val;
    logic [1:0]       w_colour_val_nxt;
    logic             r_multi_press;
    logic             w_multi_press_nxt;

    function automatic logic f_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    // Only ever called with a one-hot value; bit0=RED .. bit3=YELLOW.
    function automatic logic [1:0] f_code(input logic [3:0] v);
        logic [1:0] c;
        c = 2'b00;
        if (v[3])      c = 2'b11;
        else if (v[2]) c = 2'b10;
        else if (v[1]) c = 2'b01;
        return c;
    endfunction

    assign w_bsync       = r_sync2;
    assign w_counter_inc = (r_counter == LP_CNT_MAX) ? r_counter : r_counter + CNT_W'(1);

    // Two-flop synchroniser for the asynchronous button pads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.buttons;
            r_sync2 <= r_sync1;
        end
    end

    // State, debounce counter, captured sample and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_counter      <= '0;
            r_sample       <= '0;
            r_colour_valid <= 1'b0;
            r_colour_val   <= 2'b00;
            r_multi_press  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_counter      <= w_counter_nxt;
            r_sample       <= w_sample_nxt;
            r_colour_valid <= w_colour_valid_nxt;
            r_colour_val   <= w_colour_val_nxt;
            r_multi_press  <= w_multi_press_nxt;
        end
    end

    // Next-state and event decode; the counter is cleared on every state entry.
    always_comb begin
        w_state_nxt        = r_state;
        w_counter_nxt      = r_counter;
        w_sample_nxt       = r_sample;
        w_colour_valid_nxt = 1'b0;
        w_colour_val_nxt   = r_colour_val;
        w_multi_press_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.en && (w_bsync != 4'b0000)) begin
                    w_state_nxt   = PRESS_DB;
                    w_sample_nxt  = w_bsync;
                    w_counter_nxt = '0;
                end
            end
            PRESS_DB: begin
                if (w_bsync != r_sample) begin
                    w_state_nxt   = IDLE;
                    w_counter_nxt = '0;
                end else if (!bus.en) begin
                    // Enable dropped mid-debounce: park in HELD silently so the
                    // same press cannot produce an event later.
                    w_state_nxt   = HELD;
                    w_counter_nxt = '0;
                end else if (r_counter == LP_CNT_MAX) begin
                    w_state_nxt   = HELD;
                    w_counter_nxt = '0;
                    if (f_onehot(r_sample)) begin
                        w_colour_valid_nxt = 1'b1;
                        w_colour_val_nxt   = f_code(r_sample);
                    end else begin
                        w_multi_press_nxt  = 1'b1;
                    end
                end else begin
                    w_counter_nxt = w_counter_inc;
                end
            end
            HELD: begin
                if (w_bsync == 4'b0000) begin
                    w_state_nxt   = RELEASE_DB;
                    w_counter_nxt = '0;
                end
            end
            RELEASE_DB: begin
                if (w_bsync != 4'b0000) begin
                    w_state_nxt   = HELD;
                    w_counter_nxt = '0;
                end else if (r_counter == LP_CNT_MAX) begin
                    w_state_nxt   = IDLE;
                    w_counter_nxt = '0;
                end else begin
                    w_counter_nxt = w_counter_inc;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_counter_nxt = '0;
            end
        endcase
    end

    assign bus.colour_valid = r_colour_valid;
    assign bus.colour_val   = r_colour_val;
    assign bus.multi_press  = r_multi_press;
    assign bus.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_button_capture.sv
// Directed bench for button_capture with DEBOUNCE_CYCLES=10.
// Timing reference: inputs change 1 ns after a rising edge; "k ticks later"
// means sampled 1 ns after the k-th following rising edge. A clean press
// driven this way gives colour_valid at k=13 (2 sync edges, 1 entry edge,
// 9 count edges, 1 accept edge).
module tb_button_capture;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cv_cnt;
    int   mp_cnt;
    int   both_cnt;

    button_capture_if bus_if ();

    button_capture #(
        .DEBOUNCE_CYCLES(10),
        .CNT_W          (16)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_if.colour_valid) cv_cnt++;
        if (bus_if.multi_press) mp_cnt++;
        if (bus_if.colour_valid && bus_if.multi_press) both_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.en = 1'b1;
        bus_if.buttons = 4'b0000;
        tick(2);
        n_checks++;
        if (bus_if.colour_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cv: got %b expected 0", bus_if.colour_valid); end
        n_checks++;
        if (bus_if.colour_val !== 2'b00) begin n_fail++; $display("FAIL reset_val: got %b expected 00", bus_if.colour_val); end
        n_checks++;
        if (bus_if.multi_press !== 1'b0) begin n_fail++; $display("FAIL reset_mp: got %b expected 0", bus_if.multi_press); end
        n_checks++;
        if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
        rst = 1'b0;
        tick(3);
        n_checks++;
        if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", bus_if.busy); end
    endtask

    task automatic test_clean_press();
        int c0;
        c0 = cv_cnt;
        bus_if.buttons = 4'b0100;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            if (k == 12) begin
                n_checks++;
                if (bus_if.colour_valid !== 1'b0) begin n_fail++; $display("FAIL press_early: got %b expected 0 at k=12", bus_if.colour_valid); end
            end
            if (k == 13) begin
                n_checks++;
                if (bus_if.colour_valid !== 1'b1) begin n_fail++; $display("FAIL press_latency: got %b expected 1 at k=13", bus_if.colour_valid); end
                n_checks++;
                if (bus_if.colour_val !== 2'b10) begin n_fail++; $display("FAIL press_val: got %b expected 10", bus_if.colour_val); end
            end
            if (k == 14) begin
                n_checks++;
                if (bus_if.colour_valid !== 1'b0) begin n_fail++; $display("FAIL press_width: got %b expected 0 at k=14", bus_if.colour_valid); end
                n_checks++;
                if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL press_busy: got %b expected 1", bus_if.busy); end
            end
        end
        bus_if.buttons = 4'b0000;
        tick(12);
        n_checks++;
        if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL release_busy_hold: got %b expected 1 at k=12", bus_if.busy); end
        tick(1);
        n_checks++;
        if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL release_busy_drop: got %b expected 0 at k=13", bus_if.busy); end
        n_checks++;
        if (cv_cnt - c0 !== 1) begin n_fail++; $display("FAIL press_count: got %0d expected 1", cv_cnt - c0); end
    endtask

    task automatic test_bounce();
        int c0;
        int m0;
        c0 = cv_cnt;
        m0 = mp_cnt;
        for (int i = 0; i < 40; i++) begin
            bus_if.buttons = (((i / 3) % 2) == 0) ? 4'b0001 : 4'b0000;
            tick(1);
        end
        bus_if.buttons = 4'b0000;
        tick(20);
        n_checks++;
        if (cv_cnt - c0 !== 0) begin n_fail++; $display("FAIL bounce_cv: got %0d expected 0", cv_cnt - c0); end
        n_checks++;
        if (mp_cnt - m0 !== 0) begin n_fail++; $display("FAIL bounce_mp: got %0d expected 0", mp_cnt - m0); end
        n_checks++;
        if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL bounce_busy: got %b expected 0", bus_if.busy); end
    endtask

    task automatic test_short_press();
        int c0;
        c0 = cv_cnt;
        bus_if.buttons = 4'b0010;
        tick(9);
        bus_if.buttons = 4'b0000;
        tick(25);
        n_checks++;
        if (cv_cnt - c0 !== 0) begin n_fail++; $display("FAIL short_press_cv: got %0d expected 0", cv_cnt - c0); end
        n_checks++;
        if (bus_if.colour_val !== 2'b10) begin n_fail++; $display("FAIL short_press_val: got %b expected 10", bus_if.colour_val); end
        bus_if.buttons = 4'b0010;
        tick(12);
        bus_if.buttons = 4'b0000;
        tick(25);
        n_checks++;
        if (cv_cnt - c0 !== 1) begin n_fail++; $display("FAIL long_press_cv: got %0d expected 1", cv_cnt - c0); end
        n_checks++;
        if (bus_if.colour_val !== 2'b01) begin n_fail++; $display("FAIL long_press_val: got %b expected 01", bus_if.colour_val); end
    endtask

    task automatic test_multi_press();
        int c0;
        int m0;
        c0 = cv_cnt;
        m0 = mp_cnt;
        bus_if.buttons = 4'b0011;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            if (k == 13) begin
                n_checks++;
                if (bus_if.multi_press !== 1'b1) begin n_fail++; $display("FAIL multi_latency: got %b expected 1 at k=13", bus_if.multi_press); end
            end
        end
        bus_if.buttons = 4'b0000;
        tick(20);
        n_checks++;
        if (mp_cnt - m0 !== 1) begin n_fail++; $display("FAIL multi_count: got %0d expected 1", mp_cnt - m0); end
        n_checks++;
        if (cv_cnt - c0 !== 0) begin n_fail++; $display("FAIL multi_cv: got %0d expected 0", cv_cnt - c0); end
        n_checks++;
        if (bus_if.colour_val !== 2'b01) begin n_fail++; $display("FAIL multi_val_hold: got %b expected 01", bus_if.colour_val); end
    endtask

    task automatic test_release_bounce();
        int c0;
        c0 = cv_cnt;
        bus_if.buttons = 4'b1000;
        tick(20);
        for (int i = 0; i < 8; i++) begin
            bus_if.buttons = ((i % 2) == 0) ? 4'b0000 : 4'b1000;
            tick(1);
        end
        bus_if.buttons = 4'b0000;
        tick(25);
        n_checks++;
        if (cv_cnt - c0 !== 1) begin n_fail++; $display("FAIL rel_bounce_count: got %0d expected 1", cv_cnt - c0); end
        n_checks++;
        if (bus_if.colour_val !== 2'b11) begin n_fail++; $display("FAIL rel_bounce_val: got %b expected 11", bus_if.colour_val); end
        n_checks++;
        if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL rel_bounce_busy: got %b expected 0", bus_if.busy); end
    endtask

    task automatic test_enable();
        int c0;
        c0 = cv_cnt;
        bus_if.en = 1'b0;
        bus_if.buttons = 4'b0010;
        tick(30);
        n_checks++;
        if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL en_off_busy: got %b expected 0", bus_if.busy); end
        bus_if.en = 1'b1;
        tick(3);
        bus_if.buttons = 4'b0000;
        tick(20);
        n_checks++;
        if (cv_cnt - c0 !== 0) begin n_fail++; $display("FAIL en_late_cv: got %0d expected 0", cv_cnt - c0); end
        // Enable dropped while the press is still being debounced.
        bus_if.buttons = 4'b0100;
        tick(6);
        bus_if.en = 1'b0;
        tick(12);
        n_checks++;
        if (bus_if.busy !== 1'b1) begin n_fail++; $display("FAIL en_drop_busy: got %b expected 1", bus_if.busy); end
        bus_if.buttons = 4'b0000;
        tick(20);
        n_checks++;
        if (cv_cnt - c0 !== 0) begin n_fail++; $display("FAIL en_drop_cv: got %0d expected 0", cv_cnt - c0); end
        n_checks++;
        if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL en_drop_idle: got %b expected 0", bus_if.busy); end
        bus_if.en = 1'b1;
        bus_if.buttons = 4'b0010;
        tick(20);
        bus_if.buttons = 4'b0000;
        tick(20);
        n_checks++;
        if (cv_cnt - c0 !== 1) begin n_fail++; $display("FAIL en_next_cv: got %0d expected 1", cv_cnt - c0); end
        n_checks++;
        if (bus_if.colour_val !== 2'b01) begin n_fail++; $display("FAIL en_next_val: got %b expected 01", bus_if.colour_val); end
    endtask

    task automatic test_reset_mid_press();
        bus_if.buttons = 4'b0001;
        tick(6);
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus_if.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus_if.busy); end
        n_checks++;
        if (bus_if.colour_val !== 2'b00) begin n_fail++; $display("FAIL midrst_val: got %b expected 00", bus_if.colour_val); end
        n_checks++;
        if (bus_if.colour_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_cv: got %b expected 0", bus_if.colour_valid); end
        tick(2);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (k == 12) begin
                n_checks++;
                if (bus_if.colour_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_early: got %b expected 0 at k=12", bus_if.colour_valid); end
            end
            if (k == 13) begin
                n_checks++;
                if (bus_if.colour_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_latency: got %b expected 1 at k=13", bus_if.colour_valid); end
                n_checks++;
                if (bus_if.colour_val !== 2'b00) begin n_fail++; $display("FAIL midrst_event_val: got %b expected 00", bus_if.colour_val); end
            end
        end
        bus_if.buttons = 4'b0000;
        tick(20);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cv_cnt   = 0;
        mp_cnt   = 0;
        both_cnt = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_press();
        test_multi_press();
        test_release_bounce();
        test_enable();
        test_reset_mid_press();
        n_checks++;
        if (both_cnt !== 0) begin n_fail++; $display("FAIL exclusive_pulses: got %0d overlapping cycles expected 0", both_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
